branch_stall_controller: RTL and testbench

//  Hazard/stall sequencer for the ID-stage branch path of the 5-stage MIPS pipeline.
//  The branch forwarding unit only covers producers already in EX/MEM or MEM/WB; this block

---
 rtl/branch_stall_controller_if.sv | 39 +++
 rtl/branch_stall_controller.sv | 95 +++++++++
 tb/tb_branch_stall_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_stall_controller_if.sv
// ID-stage hazard inputs and pipeline-register control outputs of the
// branch stall controller, grouped for the pipeline top and the bench.
interface branch_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       Branch;
    logic             BranchTaken;
    logic [4:0]       IF_ID_RegisterRs;
    logic [4:0]       IF_ID_RegisterRt;
    logic             ID_EX_RegWrite;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic             EX_MEM_MemRead;
    logic [4:0]       EX_MEM_RegisterRd;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             StallActive;
    logic [CNT_W-1:0] StallCycles;

    // pipeline / decode side: supplies hazard info, consumes controls
    modport master (
        output Branch, BranchTaken, IF_ID_RegisterRs, IF_ID_RegisterRt,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_RegisterRd,
               EX_MEM_MemRead, EX_MEM_RegisterRd,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
               StallActive, StallCycles
    );

    // controller side
    modport slave (
        input  Branch, BranchTaken, IF_ID_RegisterRs, IF_ID_RegisterRt,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_RegisterRd,
               EX_MEM_MemRead, EX_MEM_RegisterRd,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
               StallActive, StallCycles
    );
endinterface

// File: rtl/branch_stall_controller.sv
// Stall sequencer for the ID-stage branch path: holds PC and IF/ID and
// bubbles ID/EX until a branch operand reaches a forwardable stage, covers
// the ordinary load-use stall and flushes IF/ID on a resolved taken branch.
module branch_stall_controller #(
    parameter int ALU_BR_STALLS = 1,
    parameter int LD_BR_STALLS  = 2,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    branch_stall_controller_if.slave bus
);
    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [1:0]       LD_N     = 2'(LD_BR_STALLS);
    localparam logic [1:0]       ALU_N    = 2'(ALU_BR_STALLS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [1:0]       cnt;
    logic [1:0]       need;
    logic             stall;
    logic             is_br;
    logic             m_ex;
    logic             m_mem;
    logic [CNT_W-1:0] stall_cycles;

    // $0 is hardwired zero, so it is never a real dependency
    function automatic logic match(input logic [4:0] x, input logic [4:0] rs,
                                   input logic [4:0] rt);
        return (x != 5'd0) && ((x == rs) || (x == rt));
    endfunction

    assign is_br = (bus.Branch != 2'b00);
    assign m_ex  = match(bus.ID_EX_RegisterRd, bus.IF_ID_RegisterRs, bus.IF_ID_RegisterRt);
    assign m_mem = match(bus.EX_MEM_RegisterRd, bus.IF_ID_RegisterRs, bus.IF_ID_RegisterRt);

    // stall cycles required by the instruction in ID, highest priority first
    always_comb begin
        need = 2'd0;
        if (is_br && bus.ID_EX_MemRead && m_ex)
            need = LD_N;
        else if (is_br && bus.ID_EX_RegWrite && m_ex)
            need = ALU_N;
        else if (is_br && bus.EX_MEM_MemRead && m_mem)
            need = 2'd1;
        else if (!is_br && bus.ID_EX_MemRead && m_ex)
            need = 2'd1;
    end

    // first stall cycle is combinational; later ones come from STALL state.
    // Reset forces the outputs to the free-running values.
    assign stall = rst_n && ((state == STALL) || (need != 2'd0));

    assign bus.StallActive  = stall;
    assign bus.PCWrite      = !stall;
    assign bus.IF_ID_Write  = !stall;
    assign bus.ID_EX_Bubble = stall;
    assign bus.IF_ID_Flush  = rst_n && is_br && bus.BranchTaken && !stall;
    assign bus.StallCycles  = stall_cycles;

    // multi-cycle stall sequencing; hazard inputs ignored once in STALL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (need > 2'd1) begin
                        cnt   <= need - 2'd1;
                        state <= STALL;
                    end
                end
                STALL: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // saturating count of stall cycles since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end
endmodule

// File: tb/tb_branch_stall_controller.sv
// Bench for branch_stall_controller: directed hazard scenarios with literal
// expectations plus randomized traffic against a pending-stall-count model.
module tb_branch_stall_controller;
    localparam int LD  = 2;
    localparam int ALU = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    branch_stall_controller_if #(.CNT_W(16)) bus ();
    branch_stall_controller_if #(.CNT_W(2))  bus2 ();

    branch_stall_controller #(.ALU_BR_STALLS(ALU), .LD_BR_STALLS(LD), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    branch_stall_controller #(.ALU_BR_STALLS(ALU), .LD_BR_STALLS(LD), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    // the saturation instance sees the same pipeline
    assign bus2.Branch            = bus.Branch;
    assign bus2.BranchTaken       = bus.BranchTaken;
    assign bus2.IF_ID_RegisterRs  = bus.IF_ID_RegisterRs;
    assign bus2.IF_ID_RegisterRt  = bus.IF_ID_RegisterRt;
    assign bus2.ID_EX_RegWrite    = bus.ID_EX_RegWrite;
    assign bus2.ID_EX_MemRead     = bus.ID_EX_MemRead;
    assign bus2.ID_EX_RegisterRd  = bus.ID_EX_RegisterRd;
    assign bus2.EX_MEM_MemRead    = bus.EX_MEM_MemRead;
    assign bus2.EX_MEM_RegisterRd = bus.EX_MEM_RegisterRd;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // rem: stall cycles still owed by an earlier decision; cnt/cnt2: stall totals
    int rem = 0, cnt = 0, cnt2 = 0;
    int nxt_rem = 0, nxt_cnt = 0, nxt_cnt2 = 0;

    function automatic bit dep(input logic [4:0] x);
        return x != 0 && (x == bus.IF_ID_RegisterRs || x == bus.IF_ID_RegisterRt);
    endfunction

    function automatic int model_need();
        bit br = bus.Branch != 0;
        if (br && bus.ID_EX_MemRead && dep(bus.ID_EX_RegisterRd))   return LD;
        if (br && bus.ID_EX_RegWrite && dep(bus.ID_EX_RegisterRd))  return ALU;
        if (br && bus.EX_MEM_MemRead && dep(bus.EX_MEM_RegisterRd)) return 1;
        if (!br && bus.ID_EX_MemRead && dep(bus.ID_EX_RegisterRd))  return 1;
        return 0;
    endfunction

    // compare process: outputs are settled mid-cycle
    always @(negedge clk) begin
        int need;
        bit st, fl;
        if (!rst_n) begin
            chk("rst_StallActive", bus.StallActive, 0);
            chk("rst_PCWrite", bus.PCWrite, 1);
            chk("rst_IF_ID_Write", bus.IF_ID_Write, 1);
            chk("rst_Bubble", bus.ID_EX_Bubble, 0);
            chk("rst_Flush", bus.IF_ID_Flush, 0);
            chk("rst_StallCycles", bus.StallCycles, 0);
            chk("rst_StallCycles2", bus2.StallCycles, 0);
            nxt_rem = 0; nxt_cnt = 0; nxt_cnt2 = 0;
        end else begin
            need = (rem > 0) ? 0 : model_need();
            st   = (rem > 0) || (need > 0);
            fl   = (bus.Branch != 0) && bus.BranchTaken && !st;
            chk("StallActive", bus.StallActive, st);
            chk("PCWrite", bus.PCWrite, !st);
            chk("IF_ID_Write", bus.IF_ID_Write, !st);
            chk("Bubble", bus.ID_EX_Bubble, st);
            chk("Flush", bus.IF_ID_Flush, fl);
            chk("StallCycles", bus.StallCycles, cnt);
            chk("StallCycles2", bus2.StallCycles, cnt2);
            chk("StallActive2", bus2.StallActive, st);
            nxt_rem  = (rem > 0) ? rem - 1 : ((need > 0) ? need - 1 : 0);
            nxt_cnt  = (st && cnt < 65535) ? cnt + 1 : cnt;
            nxt_cnt2 = (st && cnt2 < 3) ? cnt2 + 1 : cnt2;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            rem  = nxt_rem;
            cnt  = nxt_cnt;
            cnt2 = nxt_cnt2;
        end
    end

    always @(negedge rst_n) begin
        rem = 0; cnt = 0; cnt2 = 0;
        nxt_rem = 0; nxt_cnt = 0; nxt_cnt2 = 0;
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [1:0] br, input logic tk, input logic [4:0] rs,
                          input logic [4:0] rt, input logic exw, input logic exm,
                          input logic [4:0] exrd, input logic memm, input logic [4:0] memrd);
        bus.Branch = br;            bus.BranchTaken = tk;
        bus.IF_ID_RegisterRs = rs;  bus.IF_ID_RegisterRt = rt;
        bus.ID_EX_RegWrite = exw;   bus.ID_EX_MemRead = exm;
        bus.ID_EX_RegisterRd = exrd;
        bus.EX_MEM_MemRead = memm;  bus.EX_MEM_RegisterRd = memrd;
    endtask

    task automatic drive(input logic [1:0] br, input logic tk, input logic [4:0] rs,
                         input logic [4:0] rt, input logic exw, input logic exm,
                         input logic [4:0] exrd, input logic memm, input logic [4:0] memrd);
        @(posedge clk); #1;
        set_in(br, tk, rs, rt, exw, exm, exrd, memm, memrd);
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("init_PCWrite", bus.PCWrite, 1);
        chk("init_StallActive", bus.StallActive, 0);
        chk("init_StallCycles", bus.StallCycles, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: add $1 in EX, beq $1,$2 in ID -> one stall, then none
        drive(2'b01, 0, 1, 2, 1, 0, 1, 0, 0);
        look(); chk("t1_stall", bus.StallActive, 1); chk("t1_pcw", bus.PCWrite, 0);
        chk("t1_bubble", bus.ID_EX_Bubble, 1);
        drive(2'b01, 0, 1, 2, 0, 0, 0, 0, 1);
        look(); chk("t1_free", bus.StallActive, 0); chk("t1_cnt", bus.StallCycles, 1);

        // 2: lw $1 in EX, beq $2,$1 -> two stalls, second ignores inputs
        drive(2'b01, 0, 2, 1, 1, 1, 1, 0, 0);
        look(); chk("t2_stall1", bus.StallActive, 1);
        drive(2'b01, 0, 2, 1, 0, 0, 0, 1, 1);
        look(); chk("t2_stall2", bus.StallActive, 1);
        drive(2'b01, 0, 2, 1, 0, 0, 0, 0, 0);
        look(); chk("t2_free", bus.StallActive, 0); chk("t2_cnt", bus.StallCycles, 3);

        // 3: lw $3 in MEM, beq $3,$3, unrelated EX -> one stall
        drive(2'b01, 0, 3, 3, 1, 0, 5, 1, 3);
        look(); chk("t3_stall", bus.StallActive, 1);
        drive(2'b01, 0, 3, 3, 0, 0, 0, 0, 0);
        look(); chk("t3_free", bus.StallActive, 0); chk("t3_cnt", bus.StallCycles, 4);

        // 4: load-use, then the same with $0 as destination
        drive(2'b00, 0, 4, 7, 1, 1, 4, 0, 0);
        look(); chk("t4_stall", bus.StallActive, 1);
        drive(2'b00, 0, 0, 7, 1, 1, 0, 0, 0);
        look(); chk("t4_zero", bus.StallActive, 0); chk("t4_cnt", bus.StallCycles, 5);

        // 5: taken branch flush, immediate and after a load hazard
        drive(2'b01, 1, 1, 2, 0, 0, 0, 0, 0);
        look(); chk("t5_flush", bus.IF_ID_Flush, 1); chk("t5_nostall", bus.StallActive, 0);
        drive(2'b01, 1, 1, 2, 1, 1, 2, 0, 0);
        look(); chk("t5_c1_flush", bus.IF_ID_Flush, 0);
        drive(2'b01, 1, 1, 2, 0, 0, 0, 1, 2);
        look(); chk("t5_c2_flush", bus.IF_ID_Flush, 0);
        drive(2'b01, 1, 1, 2, 0, 0, 0, 0, 0);
        look(); chk("t5_c3_flush", bus.IF_ID_Flush, 1); chk("t5_cnt", bus.StallCycles, 7);

        // 6: reset during the first cycle of a two-stall sequence
        drive(2'b01, 0, 1, 2, 1, 1, 1, 0, 0);
        look(); chk("t6_stall", bus.StallActive, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_pcw", bus.PCWrite, 1);
        chk("t6_rst_stall", bus.StallActive, 0);
        chk("t6_rst_cnt", bus.StallCycles, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        set_in(2'b01, 0, 1, 2, 0, 0, 0, 0, 0);
        look(); chk("t6_idle", bus.StallActive, 0); chk("t6_cnt", bus.StallCycles, 0);

        // saturation: five single-cycle ALU stalls
        for (int i = 0; i < 5; i++) drive(2'b10, 0, 6, 1, 1, 0, 6, 0, 0);
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        look(); chk("sat_cnt16", bus.StallCycles, 5); chk("sat_cnt2", bus2.StallCycles, 3);

        // randomized traffic, small register space to provoke matches
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        look();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
